fetch_issue_unit: RTL

FETCH_ISSUE_UNIT -- requirements
Module: fetch_issue_unit

---
 rtl/upower_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 57 +++++
 rtl/fetch_issue_unit.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/upower_pkg.sv
// upower_pkg: shared types and field bounds for the fetch/issue front end.
//   state_t  : fetch FSM state (IDLE, RUN, DRAIN)
//   INSTR_W  : instruction word width
//   OP_HI/LO : primary opcode field bounds inside an instruction word
package upower_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int INSTR_W = 32;
    localparam int OP_HI   = 31;
    localparam int OP_LO   = 26;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: instruction queue, synchronous write, combinational head read.
//   clk, reset : clock, asynchronous active-high reset
//   flush      : empty the queue (wins over push/pop)
//   push, din  : enqueue din
//   pop        : drop the head entry
//   dout       : current head entry
//   count      : occupancy (0..DEPTH)
//   empty      : occupancy is zero
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 96
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr;
    logic [AW-1:0] rd;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr] <= din;
    end

    // Pointers are exactly log2(DEPTH) bits wide, so they wrap modulo DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr    <= '0;
            rd    <= '0;
            count <= '0;
        end else if (flush) begin
            wr    <= '0;
            rd    <= '0;
            count <= '0;
        end else begin
            if (push)
                wr <= wr + AW'(1);
            if (pop)
                rd <= rd + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign dout  = mem[rd];
    assign empty = (count == '0);

endmodule

// File: rtl/fetch_issue_unit.sv
// fetch_issue_unit: in-order instruction fetch with a small issue queue and redirect drain.
//   clk, reset      : clock, asynchronous active-high reset
//   start           : leave IDLE and begin fetching
//   imem_req/addr   : fetch request and word-aligned address; imem_gnt accepts it
//   imem_rvalid/rdata : in-order fetch response
//   issue_valid/ready : handshake towards decode; issue_instr/opcode/pc describe the head
//   redirect_valid/pc : flush and refetch from redirect_pc
// Build option: define FETCH_BYPASS_EN to let a response issue in its arrival cycle
// when the queue is empty.
module fetch_issue_unit
    import upower_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                imem_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic                issue_valid,
    input  logic                issue_ready,
    output logic [INSTR_W-1:0]  issue_instr,
    output logic [5:0]          issue_opcode,
    output logic [PC_W-1:0]     issue_pc,
    input  logic                redirect_valid,
    input  logic [PC_W-1:0]     redirect_pc
);

    localparam int              CW     = $clog2(DEPTH) + 1;
    localparam logic [PC_W-1:0] PC_INC = PC_W'(4);

    state_t                    state;
    state_t                    state_nx;
    logic [PC_W-1:0]           pc;
    logic [PC_W-1:0]           rsp_pc;
    logic [CW-1:0]             outstanding;
    logic [CW-1:0]             stale;
    logic [CW-1:0]             count;
    logic                      empty;
    logic                      redir;
    logic                      fire;
    logic                      rsp_any;
    logic                      rsp_ok;
    logic                      bypass;
    logic                      push;
    logic                      pop;
    logic [PC_W+INSTR_W-1:0]   head;
    logic [PC_W+INSTR_W-1:0]   cur;

    // A redirect only matters once fetching has started.
    assign redir   = redirect_valid && (state != IDLE);
    assign fire    = imem_req && imem_gnt;
    // Any response to a request of ours; after reset nothing is outstanding, so late ones are ignored.
    assign rsp_any = imem_rvalid && (outstanding != '0);
    // Responses are kept only when no flush is pending or happening.
    assign rsp_ok  = rsp_any && (state == RUN) && (stale == '0) && !redir;

`ifdef FETCH_BYPASS_EN
    assign bypass = rsp_ok && empty;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed response that decode takes right away never enters the queue.
    assign push = rsp_ok && !(bypass && issue_ready);
    assign pop  = issue_valid && issue_ready && !empty;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (PC_W + INSTR_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redir),
        .push  (push),
        .pop   (pop),
        .din   ({rsp_pc, imem_rdata}),
        .dout  (head),
        .count (count),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // DRAIN also exits when nothing stale is left, covering a redirect whose
    // only outstanding response arrived in the redirect cycle itself.
    always_comb begin
        state_nx = state;
        if (state == IDLE && start)
            state_nx = RUN;
        else if (state == RUN && redirect_valid && outstanding != '0)
            state_nx = DRAIN;
        else if (state == DRAIN && (stale == '0 || (stale == CW'(1) && imem_rvalid)))
            state_nx = RUN;
    end

    // Queued plus in-flight requests never exceed DEPTH, which reserves a slot
    // for every response before it is requested.
    always_comb begin
        imem_req     = (state == RUN) && !redirect_valid &&
                       (({1'b0, count} + {1'b0, outstanding}) < (CW+1)'(DEPTH));
        imem_addr    = pc;
        issue_valid  = (!empty || bypass) && (state != DRAIN);
        cur          = empty ? {rsp_pc, imem_rdata} : head;
        issue_instr  = issue_valid ? cur[INSTR_W-1:0] : '0;
        issue_pc     = issue_valid ? cur[PC_W+INSTR_W-1:INSTR_W] : '0;
        issue_opcode = issue_instr[OP_HI:OP_LO];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            stale       <= '0;
        end else begin
            outstanding <= outstanding + CW'(fire) - CW'(rsp_any);
            if (redir) begin
                pc     <= redirect_pc;
                rsp_pc <= redirect_pc;
                stale  <= outstanding - CW'(rsp_any);
            end else begin
                if (fire)
                    pc <= pc + PC_INC;
                if (rsp_ok)
                    rsp_pc <= rsp_pc + PC_INC;
                if (stale != '0 && imem_rvalid)
                    stale <= stale - CW'(1);
            end
        end
    end

endmodule
